// File: rtl/cycle_ctrl.sv
// -----------------------------------------------------------------------------
// cycle_ctrl - instruction cycle sequencer for the picoMIPS core.
//
// Walks every instruction through FETCH, DEC1, DEC2 and EXEC. It can insert
// multiply wait states (MWAIT) between DEC2 and EXEC. A HALT instruction parks
// the sequencer, and single-step debug mode pauses it after each EXEC.
// A synchronised rising edge on the resume pushbutton releases HALT or PAUSE.
//
// Parameters:
//   MULT_CYCLES  wait cycles inserted for a multiply (0 = none)
//   SYNC_STAGES  depth of the resume synchronizer (values below 2 act as 2)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   is_mult      decoder flag, sampled on the edge that leaves DEC2
//   is_halt      decoder flag, sampled on the edge that leaves DEC2
//   step_mode    debug switch level, sampled on the edge that leaves EXEC
//   resume       asynchronous pushbutton; only its rising edges are used
//   cycle        one-hot phase (FETCH/DEC1/DEC2/EXEC); all zeros in
//                MWAIT/HALT/PAUSE
//   pc_en        PC advance enable, high exactly in EXEC
//   halted       high while in HALT
//   paused       high while in PAUSE
//   instr_count  number of completed EXEC cycles, saturating at 0xFFFF
// -----------------------------------------------------------------------------
`ifndef CYCLE_SIZE
`define CYCLE_SIZE  4
`define CYCLE_FETCH 0
`define CYCLE_DEC1  1
`define CYCLE_DEC2  2
`define CYCLE_EXEC  3
`endif

module cycle_ctrl #(
  parameter int MULT_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_mult,
  input  logic                   is_halt,
  input  logic                   step_mode,
  input  logic                   resume,
  output logic [`CYCLE_SIZE-1:0] cycle,
  output logic                   pc_en,
  output logic                   halted,
  output logic                   paused,
  output logic [15:0]            instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_DEC1  = 3'd1,
    ST_DEC2  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5,
    ST_PAUSE = 3'd6
  } state_t;

  localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W    = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam bit HAS_WAIT = (MULT_CYCLES > 0);
  // MWAIT exits on the cycle the counter reads zero, so load one less than
  // the wait length.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULT_CYCLES > 0) ? (MULT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                   state_r, state_s;
  logic [CNT_W-1:0]         wait_cnt_r, wait_cnt_s;
  logic                     mult_q_r, halt_q_r;
  logic [SYNC_N-1:0]        sync_r;
  logic                     prev_r;
  logic                     edge_s;
  logic [`CYCLE_SIZE-1:0]   cycle_r;
  logic                     pc_en_r, halted_r, paused_r;
  logic [15:0]              count_r;

  // One-hot phase decode of a state; wait, halt and pause states show no phase.
  function automatic logic [`CYCLE_SIZE-1:0] decode_cycle(input state_t s);
    logic [`CYCLE_SIZE-1:0] v;
    v = '0;
    case (s)
      ST_FETCH: v[`CYCLE_FETCH] = 1'b1;
      ST_DEC1:  v[`CYCLE_DEC1]  = 1'b1;
      ST_DEC2:  v[`CYCLE_DEC2]  = 1'b1;
      ST_EXEC:  v[`CYCLE_EXEC]  = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  // A resume edge counts only if it is seen while HALT or PAUSE is waiting for it.
  assign edge_s = sync_r[SYNC_N-1] & ~prev_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      ST_FETCH: state_s = ST_DEC1;
      ST_DEC1:  state_s = ST_DEC2;
      ST_DEC2: begin
        if (is_mult && HAS_WAIT) begin
          state_s    = ST_MWAIT;
          wait_cnt_s = CNT_LOAD;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_MWAIT: begin
        // Also leave MWAIT if the multiply flag is not latched, so the
        // sequencer cannot stall on a corrupted count.
        if ((wait_cnt_r == '0) || !mult_q_r) begin
          state_s = ST_EXEC;
        end else begin
          wait_cnt_s = wait_cnt_r - CNT_ONE;
        end
      end
      ST_EXEC: begin
        if (halt_q_r) begin
          state_s = ST_HALT;
        end else if (step_mode) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HALT, ST_PAUSE: begin
        if (edge_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_FETCH;
    endcase
  end

  // State, counters and latched flags. Outputs are registered from the next
  // state, so they always match the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= '0;
      mult_q_r   <= 1'b0;
      halt_q_r   <= 1'b0;
      count_r    <= 16'h0000;
      cycle_r    <= decode_cycle(ST_FETCH);
      pc_en_r    <= 1'b0;
      halted_r   <= 1'b0;
      paused_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (state_r == ST_DEC2) begin
        mult_q_r <= is_mult;
        halt_q_r <= is_halt;
      end else if (state_s == ST_FETCH) begin
        mult_q_r <= 1'b0;
        halt_q_r <= 1'b0;
      end
      if ((state_r == ST_EXEC) && (count_r != 16'hFFFF)) begin
        count_r <= count_r + 16'h0001;
      end
      cycle_r  <= decode_cycle(state_s);
      pc_en_r  <= (state_s == ST_EXEC);
      halted_r <= (state_s == ST_HALT);
      paused_r <= (state_s == ST_PAUSE);
    end
  end

  // Resume pushbutton synchronizer and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_N-2:0], resume};
      prev_r <= sync_r[SYNC_N-1];
    end
  end

  assign cycle       = cycle_r;
  assign pc_en       = pc_en_r;
  assign halted      = halted_r;
  assign paused      = paused_r;
  assign instr_count = count_r;

endmodule

// File: doc/cycle_ctrl.md
# cycle_ctrl

Instruction cycle sequencer for the picoMIPS core. Generates the one-hot `cycle` vector (FETCH, DEC1, DEC2, EXEC) that times the register file's read-address muxing, output-1 capture and EXEC-cycle writes. Also inserts multiply wait states, implements a HALT instruction and single-step debug mode, and counts executed instructions. Sits beside the decoder and drives `regs`, the PC and the ALU.

## Interface
Parameters:
- MULT_CYCLES, 2, number of wait cycles inserted between DEC2 and EXEC when the instruction is a multiply; 0 means no wait state.
- SYNC_STAGES, 2, depth of the `resume` input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- is_mult  in  1  decoder flag; sampled on the DEC2 edge.
- is_halt  in  1  decoder flag; sampled on the DEC2 edge.
- step_mode  in  1  level from a switch; sampled on the EXEC edge.
- resume  in  1  asynchronous pushbutton; only its rising edges are used.
- cycle  out  `CYCLE_SIZE  one-hot phase: bits `CYCLE_FETCH, `CYCLE_DEC1, `CYCLE_DEC2, `CYCLE_EXEC.
- pc_en  out  1  PC advance enable; equal to cycle[`CYCLE_EXEC].
- halted  out  1  high while in HALT.
- paused  out  1  high while in PAUSE.
- instr_count  out  16  count of completed EXEC cycles, saturating.

## Operation
- States: FETCH, DEC1, DEC2, MWAIT, EXEC, HALT, PAUSE.
- `cycle` encoding by state:
  - FETCH, DEC1, DEC2 and EXEC each drive their own bit.
  - MWAIT, HALT and PAUSE drive all zeros. No register write and no PC advance occurs in these states.
- Transitions:
  - FETCH→DEC1→DEC2.
  - DEC2 latches is_mult and is_halt into mult_q and halt_q.
  - DEC2→MWAIT if is_mult and MULT_CYCLES>0; otherwise DEC2→EXEC.
  - MWAIT: a down-counter is loaded with MULT_CYCLES-1 on entry. The state is left for EXEC when the counter reaches 0, so MWAIT lasts exactly MULT_CYCLES cycles.
  - EXEC→HALT if halt_q.
  - Otherwise EXEC→PAUSE if step_mode.
  - Otherwise EXEC→FETCH.
  - HALT and PAUSE → FETCH on a resume edge; otherwise they hold.
- Priorities:
  - Halt beats step mode: halted=1 and paused=0.
  - An instruction flagged both mult and halt gets its full wait, then EXEC, then HALT.
- Resume edge detection:
  - `resume` passes through a SYNC_STAGES-flop synchronizer, then a prev register.
  - edge = sync_out & ~prev.
  - An edge seen in any state other than HALT or PAUSE is discarded, not queued.
- instr_count: +1 on every EXEC cycle; sticks at 0xFFFF.
- Both latched flags clear when FETCH is entered.

## Timing
- Reset values:
  - State is FETCH, so `cycle` has only the FETCH bit set.
  - pc_en=0, halted=0, paused=0, instr_count=0.
  - MWAIT counter=0, mult_q=halt_q=0.
  - All synchronizer flops and prev=0.
- Reset mid-operation from any state: FETCH on the next edge. A pending wait count and the latched flags are abandoned.
- Latency:
  - Normal instruction: 4 cycles.
  - Multiply: 4+MULT_CYCLES cycles.
  - Back-to-back instructions have no bubble.
- Resume latency: with `resume` rising before edge N, sync_out is high after edge N+SYNC_STAGES-1. The state leaves HALT/PAUSE on edge N+SYNC_STAGES, so FETCH is visible in the following cycle.
- One press advances exactly one instruction in step mode. Holding the button gives no further edges.
- A button held through reset produces one post-reset edge. It arrives while the sequencer is in FETCH..EXEC and is discarded.
- `cycle` and status outputs are registered; they are a pure decode of the state register with no input-to-output combinational path.
- step_mode changes take effect at the next EXEC only.

## Test plan
- Reset held 3 cycles, then 3 normal instructions (is_mult=is_halt=0):
  - Required: `cycle` sequence FETCH,DEC1,DEC2,EXEC repeated with no gaps.
  - Required: pc_en high only in EXEC; instr_count=3 after the third EXEC.
- is_mult=1 at DEC2 with MULT_CYCLES=2:
  - Required: DEC2, two all-zero cycles, EXEC; instruction takes 6 cycles.
  - Repeat with MULT_CYCLES=0: 4 cycles, no zero cycles.
- is_halt=1 at DEC2:
  - Required: EXEC follows, then halted=1 and `cycle`=0, holding indefinitely.
  - Pulse resume 1→0 (4 cycles high): halted drops and FETCH is entered exactly SYNC_STAGES+1 edges after the rise.
- step_mode=1 with 2 resume presses:
  - Required: paused=1 after each EXEC; exactly one instruction per press; instr_count advances by 1 per press.
  - A resume pulse during DEC1 is ignored: no skipped pause.
- Priority and reset cases:
  - is_halt and is_mult together with step_mode=1: required order is wait, EXEC, halted=1, paused=0.
  - Reset asserted during MWAIT: required FETCH next cycle, counter cleared.
- Preload instr_count near 0xFFFF via force, then run 3 EXECs: required value stays at 0xFFFF.
